hazard_stall_unit: RTL
======================

# hazard_stall_unit

Read-after-write hazard detector for the five-stage 16-bit pipeline. It sits beside the decode stage and produces the `haz_stall` input consumed by the instruction decoder. It keeps a small scoreboard of destination registers in flight (EX, MEM, WB), compares it against the source registers of the instruction in ID, and holds IF/ID while injecting a bubble into EX until the hazard clears. It also keeps a saturating stall-cycle counter for performance runs.

## Interface
- `FORWARD`, default 0. Hazard policy.
  - 0: no forwarding; stall on any match in EX or MEM.
  - 1: EX/MEM forwarding exists; stall only on a load-use match in EX.
- `CNT_W`, default 16. Width of the stall counter.
- Ports:
  - `clk`  in  1  single clock; all state updates on the rising edge.
  - `rst_n`  in  1  asynchronous, active-low reset.
  - `id_valid`  in  1  ID holds a real instruction (0 for a bubble or NOP).
  - `id_rs`  in  3  first source register of the ID instruction.
  - `id_rt`  in  3  second source register of the ID instruction.
  - `id_rs_used`  in  1  the ID instruction reads `id_rs`.
  - `id_rt_used`  in  1  the ID instruction reads `id_rt`.
  - `id_rd`  in  3  destination register of the ID instruction.
  - `id_reg_write`  in  1  the ID instruction writes `id_rd`.
  - `id_ld`  in  1  the ID instruction is a load.
  - `flush`  in  1  a taken branch or jump resolved this cycle; the ID instruction is squashed.
  - `haz_stall`  out  1  hold PC and IF/ID, and insert a bubble into EX.
  - `ex_busy`  out  1  the EX scoreboard entry is valid and writes a register (debug).
  - `stall_cnt`  out  CNT_W  number of stall cycles, saturating.

## Operation
- Scoreboard: three entries, EX, MEM and WB. Each entry holds {v, rd[2:0], ld}. An entry is valid (v) only when the instruction writes a register.
- Every cycle the scoreboard shifts: WB←MEM, MEM←EX, EX←new.
  - new = {id_valid & id_reg_write, id_rd, id_ld} when no stall and no flush.
  - new = bubble {0, 0, 0} otherwise.
- Match against entry E: E.v & ((id_rs_used & id_rs==E.rd) | (id_rt_used & id_rt==E.rd)).
- Register file writes before it reads (internal bypass), so the WB entry never causes a stall. WB is tracked for debug only.
- Hazard condition:
  - FORWARD=0: hazard = id_valid & (match(EX) | match(MEM)).
  - FORWARD=1: hazard = id_valid & match(EX) & EX.ld.
- Output: haz_stall = hazard & ~flush. A squashed instruction never stalls.
- During a stall, ID inputs are held stable by the IF/ID register. The scoreboard keeps shifting, so the hazard clears once the producer drains.
- R0 is an ordinary register (no hardwired zero). A match on register 0 stalls like any other register.
- Counter: stall_cnt increments by 1 on every cycle with haz_stall=1. It saturates at 2^CNT_W−1 and never wraps.
- flush and hazard in the same cycle:
  - flush wins; haz_stall=0.
  - EX receives a bubble.
  - The counter does not increment.

## Timing
- haz_stall is combinational from the current scoreboard and the ID inputs, in the same cycle. There is no registered delay.
- Maximum stall length:
  - FORWARD=0: 2 cycles (producer in EX, then in MEM).
  - FORWARD=1: 1 cycle (load-use only).
- The scoreboard and counter update on the rising clk edge.
- rst_n low, asynchronously:
  - all entries cleared (v=0, rd=0, ld=0);
  - stall_cnt=0;
  - haz_stall=0 and ex_busy=0 immediately.
- Reset asserted mid-stall drops haz_stall in the same cycle. After rst_n deasserts, the first edge loads EX from ID normally.
- Back-to-back dependent chains each stall independently; no hazard is suppressed by an earlier stall.

## Test plan
- FORWARD=0: `ADD r3←r1,r2`, then `ADD r4←r3,r5` → haz_stall=1 for 2 cycles, 0 on the third; stall_cnt=2; EX receives 2 bubbles.
- FORWARD=0: producer r3, one independent instruction, then consumer of r3 → 1 stall cycle. With two independent instructions in between → 0 stall cycles.
- FORWARD=1: `LD r2`, then consumer of r2 via rt → 1 stall cycle. An ALU producer followed by a consumer → 0 stalls.
- flush=1 in a cycle where the hazard condition holds → haz_stall=0; EX←bubble; stall_cnt unchanged.
- Consumer with id_rs_used=0 and a matching id_rs → no stall. id_valid=0 with a matching source → no stall.
- CNT_W=4, force 20 stall cycles → stall_cnt saturates at 15. Pulse rst_n low mid-stall → haz_stall=0, stall_cnt=0, ex_busy=0 immediately.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// RAW hazard detector beside decode: tracks in-flight destinations (EX/MEM/WB)
// and stalls IF/ID, injecting an EX bubble, until the producer drains.
module hazard_stall_unit #(
    parameter int FORWARD = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [2:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_ld,
    input  logic             flush,
    output logic             haz_stall,
    output logic             ex_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       v;
        logic [2:0] rd;
        logic       ld;
    } sb_entry_t;

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic match_ex, match_mem, hazard;
    logic sb_unused;

    function automatic logic src_match(input sb_entry_t e);
        return e.v & ((id_rs_used & (id_rs == e.rd)) | (id_rt_used & (id_rt == e.rd)));
    endfunction

    always_comb begin
        match_ex  = src_match(ex_q);
        match_mem = src_match(mem_q);
        hazard    = 1'b0;
        if (FORWARD == 0) begin
            hazard = id_valid & (match_ex | match_mem);
        end else begin
            hazard = id_valid & match_ex & ex_q.ld;
        end
    end

    // A squashed instruction never stalls, so flush masks the hazard.
    assign haz_stall = hazard & ~flush;
    assign ex_busy   = ex_q.v;
    assign stall_cnt = cnt_q;

    always_comb begin
        ex_d  = '0;
        cnt_d = cnt_q;
        if (!haz_stall && !flush) begin
            ex_d.v  = id_valid & id_reg_write;
            ex_d.rd = id_rd;
            ex_d.ld = id_ld;
        end
        if (haz_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    // WB (and MEM.ld) are debug-only state with no consumer in this block.
    assign sb_unused = ^{wb_q, mem_q};

endmodule
